uarc_recv_arbiter: RTL

UARC_RECV_ARBITER -- requirements
Module: uarc_recv_arbiter

---
 rtl/uarc_pkg.sv | 19 +
 rtl/uarc_recv_arbiter_rr_select.sv | 57 +++++
 rtl/uarc_recv_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/uarc_pkg.sv
// Shared types and width helpers for the receive-bus interrupt arbiter.
package uarc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_ACK
    } state_e;

    function automatic int word_width(input int mag);
        return 1 << mag;
    endfunction

    // Index width never collapses to zero, even with a single bus.
    function automatic int bus_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uarc_recv_arbiter_rr_select.sv
// Combinational round-robin pick: lowest set line at or above ptr, else lowest overall.
module priority_encoder #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  lines,
    output logic [IW-1:0] idx,
    output logic          on
);
    always_comb begin
        idx = '0;
        on  = |lines;
        for (int i = N - 1; i >= 0; i--) begin
            if (lines[i]) idx = IW'(i);
        end
    end
endmodule

module rr_select #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  lines,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          on
);
    logic [N-1:0]  hi_mask;
    logic [N-1:0]  masked;
    logic [IW-1:0] m_idx, u_idx;
    logic          m_on, u_on;

    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < N; i++) begin
            hi_mask[i] = (i >= int'(ptr));
        end
    end

    assign masked = lines & hi_mask;

    priority_encoder #(.N(N), .IW(IW)) u_pe_masked (
        .lines (masked),
        .idx   (m_idx),
        .on    (m_on)
    );

    priority_encoder #(.N(N), .IW(IW)) u_pe_all (
        .lines (lines),
        .idx   (u_idx),
        .on    (u_on)
    );

    // Nothing at or above ptr means the search wraps back to bus 0.
    assign idx = m_on ? m_idx : u_idx;
    assign on  = u_on;
endmodule

// File: rtl/uarc_recv_arbiter.sv
// Arbitrates receiver send requests into a single interrupt offer to core0, with four-phase ack.
module uarc_recv_arbiter
    import uarc_pkg::*;
#(
    parameter  int WORD_MAG    = 5,
    parameter  int TOTAL_BUSES = 4,
    localparam int WORD_WIDTH  = word_width(WORD_MAG),
    localparam int BUS_W       = bus_w(TOTAL_BUSES)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [TOTAL_BUSES-1:0]                 receiver_enable,
    input  logic [TOTAL_BUSES-1:0]                 receiver_sends,
    input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_datas,
    input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_self_permissions,
    input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_self_addresses,
    output logic [TOTAL_BUSES-1:0]                 receiver_send_acks,
    input  logic                                   int_mask,
    output logic                                   int_valid,
    input  logic                                   int_accept,
    output logic [BUS_W-1:0]                       int_bus,
    output logic [WORD_WIDTH-1:0]                  int_data,
    output logic [WORD_WIDTH-1:0]                  int_permission,
    output logic [WORD_WIDTH-1:0]                  int_address
);
    state_e                   state_q;
    logic [BUS_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [BUS_W-1:0]         bus_q;
    logic [WORD_WIDTH-1:0]    data_q, perm_q, addr_q;
    logic                     valid_q;
    logic [TOTAL_BUSES-1:0]   acks_q;
    logic [TOTAL_BUSES-1:0]   eligible;
    logic [TOTAL_BUSES-1:0]   grant_oh;
    logic [BUS_W-1:0]         pick_idx;
    logic                     pick_on;

    assign eligible = receiver_sends & receiver_enable;

    rr_select #(.N(TOTAL_BUSES), .IW(BUS_W)) u_rr_select (
        .lines (eligible),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .on    (pick_on)
    );

    always_comb begin
        grant_oh        = '0;
        grant_oh[bus_q] = 1'b1;
    end

    assign rr_ptr_d = (bus_q == BUS_W'(TOTAL_BUSES - 1)) ? '0 : bus_q + BUS_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            bus_q    <= '0;
            data_q   <= '0;
            perm_q   <= '0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            acks_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!int_mask && pick_on) begin
                        state_q <= ST_OFFER;
                        bus_q   <= pick_idx;
                        data_q  <= receiver_datas[pick_idx];
                        perm_q  <= receiver_self_permissions[pick_idx];
                        addr_q  <= receiver_self_addresses[pick_idx];
                        valid_q <= 1'b1;
                    end
                end
                ST_OFFER: begin
                    // Accept beats a same-cycle withdrawal; the mask is only consulted in IDLE.
                    if (int_accept) begin
                        state_q <= ST_ACK;
                        valid_q <= 1'b0;
                        acks_q  <= grant_oh;
                    end else if (!eligible[bus_q]) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                ST_ACK: begin
                    if (!eligible[bus_q]) begin
                        state_q  <= ST_IDLE;
                        acks_q   <= '0;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    acks_q  <= '0;
                end
            endcase
        end
    end

    assign receiver_send_acks = acks_q;
    assign int_valid          = valid_q;
    assign int_bus            = bus_q;
    assign int_data           = data_q;
    assign int_permission     = perm_q;
    assign int_address        = addr_q;
endmodule
